qbert_switch_pio: RTL and testbench
===================================

// Module: qbert_switch_pio
// PURPOSE
//  Parametrised Avalon-MM input PIO for board switches/buttons.
//  Adds 2-FF synchroniser, per-bit debounce, edge capture and maskable IRQ.
//  Avalon slave on the NIOS data bus; IRQ goes to the NIOS interrupt controller.
// PARAMETERS
//  WIDTH            4   input bit count, 1..32
//  DEBOUNCE_CYCLES  16  consecutive stable clk cycles before accepting a change, >=1
//  EDGE_TYPE        0   capture mode: 0 rising, 1 falling, 2 any edge
// PORTS
//  clk         in   1      system clock
//  reset       in   1      synchronous, active-high reset
//  address     in   2      register select
//  chipselect  in   1      slave select
//  write_n     in   1      active-low write strobe, valid with chipselect
//  writedata   in   32     write data
//  in_port     in   WIDTH  asynchronous switch inputs
//  readdata    out  32     registered read data, zero-extended above WIDTH
//  irq         out  1      level interrupt, registered
// BEHAVIOUR
//  Interface: one clock, clk; reset is synchronous and active-high.
//  Reset: readdata=0, irq=0, sync FFs=0, stable=0, edge_cap=0, irq_mask=0, counters=0.
//  Register map (readdata reflects address sampled on the prior edge):
//   0 DATA      RO  debounced stable value
//   1 RAW       RO  synchronised, undebounced value
//   2 IRQMASK   RW  WIDTH bits; writedata[WIDTH-1:0] stored
//   3 EDGECAP   R/W1C  captured edges; writing 1 clears that bit
//  Read latency: 1 cycle. readdata updates every cycle regardless of chipselect.
//  Writes: take effect when chipselect=1 and write_n=0; writes to 0/1 are ignored.
//  Sync: sync = 2-FF chain of in_port, 2 cycles of latency.
//  Debounce (per bit): if sync==stable, cnt<=0; else cnt<=cnt+1. When
//   cnt==DEBOUNCE_CYCLES-1 and sync!=stable, stable<=sync and cnt<=0.
//   Counter width is $clog2(DEBOUNCE_CYCLES+1). A glitch shorter than
//   DEBOUNCE_CYCLES restarts the count. A clean step first appears on DATA
//   2+DEBOUNCE_CYCLES cycles after in_port changes.
//  Edge detect: stable_d is stable delayed one cycle. rise=stable&~stable_d,
//   fall=~stable&stable_d. The selected edge sets edge_cap the cycle after the change.
//  Set and W1C on the same bit in the same cycle: set wins, and the bit stays 1.
//  irq <= |(edge_cap & irq_mask), registered, so it lags edge_cap by 1 cycle.
//  Boundary cases:
//   - An input held high through reset yields a rising capture once reset is
//     released; software must clear EDGECAP after init.
//   - Reset asserted mid-debounce or mid-transaction clears all state on the next edge.
//   - Counters saturate by construction and cannot wrap.
//   - WIDTH=32 uses no zero padding.
// CONFIGURATION
//  QBERT_SWITCH_PIO_DEBOUNCE_EN
//   defined: debounce counters are built as described above.
//   undefined: stable<=sync every cycle, so DATA lags in_port by 3 cycles.
//     No counters are built and DEBOUNCE_CYCLES is ignored.
//   RAW, edge and IRQ logic behave the same in both builds.
// STRUCTURE
//  Package qbert_pio_pkg:
//   - address constants ADDR_DATA=0, ADDR_RAW=1, ADDR_IRQMASK=2, ADDR_EDGECAP=3
//   - EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2
//  Sub-module qbert_switch_debounce: one bit of sync + counter + stable,
//   instantiated WIDTH times via generate. Edge, mask, IRQ and bus logic stay in the top level.
// TESTING (WIDTH=4, DEBOUNCE_CYCLES=8, EDGE_TYPE=0)
//  1 Reset with in_port=0: read each address -> readdata=0; irq=0.
//  2 in_port 0->4'h5 held: DATA reads 0 until cycle 9, 4'h5 from cycle 10;
//    EDGECAP=4'h5 one cycle later.
//  3 in_port[0] pulses high for 5 cycles: DATA stays 0, EDGECAP stays 0; RAW shows the pulse.
//  4 Write IRQMASK=4'h1, then step in_port[0] high: irq=1 one cycle after
//    EDGECAP[0] sets; write EDGECAP=4'h1 -> irq=0 two cycles later.
//  5 W1C of bit 2 in the same cycle bit 2 captures an edge: EDGECAP[2] remains 1.
//  6 Assert reset while in_port[1] is mid-debounce (cnt=5): all registers 0;
//    after release DATA[1] updates 2+8 cycles later.
//  Repeat 2-3 with the macro undefined: DATA follows in_port after 3 cycles.

Source files
------------

// File: rtl/qbert_pio_pkg.sv
// Shared constants for the switch/button PIO: register addresses and edge-capture modes.
// Latency: n/a (constants only).
// Backpressure: n/a.
package qbert_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RAW     = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/qbert_switch_debounce.sv
// One input bit: 2-FF synchroniser followed by a debounce counter that yields the stable value.
// Latency: sync 2 cycles; stable 2+DEBOUNCE_CYCLES cycles (3 cycles without debounce).
// Backpressure: none; free-running per clock.
// Ports: clk, reset (sync, active-high), in_bit (async), sync (synchronised bit), stable (debounced bit).
// Build option: QBERT_SWITCH_PIO_DEBOUNCE_EN enables the counter; otherwise stable follows sync.
module qbert_switch_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic in_bit,
    output logic sync,
    output logic stable
);

    if (DEBOUNCE_CYCLES < 1) begin : g_cfg_check
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= in_bit;
            sync <= meta;
        end
    end

`ifdef QBERT_SWITCH_PIO_DEBOUNCE_EN
    // Counter is wide enough to hold DEBOUNCE_CYCLES; it is cleared on acceptance
    // or on any return to the stable value, so it never reaches its top and wraps.
    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (sync == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            stable <= sync;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            stable <= 1'b0;
        end else begin
            stable <= sync;
        end
    end
`endif

endmodule

// File: rtl/qbert_switch_pio.sv
// Avalon-MM input PIO: synchronised/debounced switches, edge capture (W1C) and maskable level IRQ.
// Latency: readdata 1 cycle after address; edge_cap 1 cycle after stable changes; irq 1 cycle after edge_cap.
// Backpressure: none; the slave accepts every access in a single cycle (no waitrequest).
// Ports: clk, reset (sync, active-high), address[1:0], chipselect, write_n, writedata[31:0],
//        in_port[WIDTH-1:0] (async), readdata[31:0] (registered, zero-extended), irq (registered).
// Build option: QBERT_SWITCH_PIO_DEBOUNCE_EN builds per-bit debounce counters.
module qbert_switch_pio
    import qbert_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] w1c;
    logic [31:0]      rd_next;
    logic             wr;
    logic             unused_wdata;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        qbert_switch_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .reset  (reset),
            .in_bit (in_port[g]),
            .sync   (raw[g]),
            .stable (stable[g])
        );
    end

    // Bits of writedata above WIDTH carry no register state.
    assign unused_wdata = ^writedata;

    assign wr  = chipselect && !write_n;
    assign w1c = (wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        edge_hit = '0;
        case (EDGE_TYPE)
            EDGE_RISE: edge_hit = stable & ~stable_d;
            EDGE_FALL: edge_hit = ~stable & stable_d;
            default:   edge_hit = stable ^ stable_d;
        endcase
    end

    always_comb begin
        rd_next = '0;
        case (address)
            ADDR_DATA:    rd_next = 32'(stable);
            ADDR_RAW:     rd_next = 32'(raw);
            ADDR_IRQMASK: rd_next = 32'(irq_mask);
            ADDR_EDGECAP: rd_next = 32'(edge_cap);
            default:      rd_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stable_d <= '0;
            edge_cap <= '0;
            irq_mask <= '0;
            irq      <= 1'b0;
            readdata <= '0;
        end else begin
            stable_d <= stable;
            if (wr && address == ADDR_IRQMASK) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
            // OR-ing the new edge after the clear lets a coincident capture survive the W1C.
            edge_cap <= (edge_cap & ~w1c) | edge_hit;
            irq      <= |(edge_cap & irq_mask);
            readdata <= rd_next;
        end
    end

endmodule

// File: tb/tb_qbert_switch_pio.sv
// Directed bench for qbert_switch_pio (WIDTH=4, DEBOUNCE_CYCLES=8, rising-edge capture).
// Latency: n/a.
// Backpressure: n/a.
module tb_qbert_switch_pio;

    localparam int WIDTH = 4;
    localparam int DCYC  = 8;
`ifdef QBERT_SWITCH_PIO_DEBOUNCE_EN
    // Edge on which stable takes a new value, counting the first edge that samples in_port as 0.
    localparam int L = DCYC + 1;
    localparam logic [31:0] GLITCH_CAP = 32'h0;
`else
    localparam int L = 2;
    localparam logic [31:0] GLITCH_CAP = 32'h1;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [WIDTH-1:0] in_port;
    logic [31:0]      readdata;
    logic             irq;

    int checks = 0;
    int errors = 0;

    qbert_switch_pio #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DCYC),
        .EDGE_TYPE       (0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  addr;
        logic        cs;
        logic        wn;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sel(input logic [1:0] a);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        tick();
        write_n    = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Register-access vectors: each drives one edge, readdata shows the pre-edge register.
        vecs[0]  = '{2'd0, 1'b1, 1'b1, 32'h0,        32'h0, 1'b0};
        vecs[1]  = '{2'd1, 1'b1, 1'b1, 32'h0,        32'h0, 1'b0};
        vecs[2]  = '{2'd2, 1'b1, 1'b1, 32'h0,        32'h0, 1'b0};
        vecs[3]  = '{2'd3, 1'b1, 1'b1, 32'h0,        32'h0, 1'b0};
        vecs[4]  = '{2'd2, 1'b1, 1'b0, 32'hFFFF_FFFA, 32'h0, 1'b0};
        vecs[5]  = '{2'd2, 1'b1, 1'b1, 32'h0,        32'hA, 1'b0};
        vecs[6]  = '{2'd0, 1'b1, 1'b0, 32'hF,        32'h0, 1'b0};
        vecs[7]  = '{2'd1, 1'b1, 1'b0, 32'hF,        32'h0, 1'b0};
        vecs[8]  = '{2'd2, 1'b0, 1'b0, 32'h5,        32'hA, 1'b0};
        vecs[9]  = '{2'd2, 1'b1, 1'b1, 32'h3,        32'hA, 1'b0};
        vecs[10] = '{2'd2, 1'b1, 1'b1, 32'h0,        32'hA, 1'b0};
        vecs[11] = '{2'd3, 1'b1, 1'b0, 32'hF,        32'h0, 1'b0};
        vecs[12] = '{2'd2, 1'b1, 1'b0, 32'h0,        32'hA, 1'b0};
        vecs[13] = '{2'd2, 1'b1, 1'b1, 32'h0,        32'h0, 1'b0};

        reset      = 1'b1;
        in_port    = '0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        repeat (3) tick();
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        reset = 1'b0;

        // Reset state of every register, then IRQMASK access rules.
        for (int i = 0; i < 14; i++) begin
            address    = vecs[i].addr;
            chipselect = vecs[i].cs;
            write_n    = vecs[i].wn;
            writedata  = vecs[i].wd;
            tick();
            check($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
            check($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].exp_irq));
        end
        write_n = 1'b1;

        // Short pulse on bit 0: visible on RAW, rejected by the debouncer.
        sel(2'd1);
        in_port = 4'h1;
        tick();                       // edge 0
        tick();                       // edge 1: sync high
        tick();                       // edge 2: RAW read shows it
        check("glitch_raw_high", readdata, 32'h1);
        tick();
        tick();                       // edge 4: fifth sampled-high edge
        in_port = 4'h0;
        repeat (L + 4) tick();
        check("glitch_raw_low", readdata, 32'h0);
        sel(2'd0);
        tick();
        check("glitch_data", readdata, 32'h0);
        sel(2'd3);
        tick();
        check("glitch_edgecap", readdata, GLITCH_CAP);
        wr(2'd3, 32'hF);

        // Clean step 0 -> 5.
        sel(2'd0);
        in_port = 4'h5;
        tick();
        repeat (L) tick();
        check("step_data_before", readdata, 32'h0);
        tick();
        check("step_data_after", readdata, 32'h5);
        sel(2'd3);
        tick();
        check("step_edgecap", readdata, 32'h5);
        check("step_irq_masked", 32'(irq), 32'h0);
        wr(2'd3, 32'hF);
        tick();
        check("step_edgecap_cleared", readdata, 32'h0);

        // Falling edges are not captured in rising mode.
        in_port = 4'h0;
        repeat (L + 4) tick();
        check("fall_no_capture", readdata, 32'h0);

        // Masked IRQ timing and W1C release.
        wr(2'd2, 32'h1);
        sel(2'd3);
        in_port = 4'h1;
        tick();
        repeat (L) tick();
        tick();                       // edge L+1: edge_cap[0] sets
        check("irq_lag_low", 32'(irq), 32'h0);
        tick();                       // edge L+2
        check("irq_high", 32'(irq), 32'h1);
        check("irq_edgecap", readdata, 32'h1);
        write_n   = 1'b0;
        writedata = 32'h1;
        tick();                       // W1C edge
        write_n   = 1'b1;
        check("irq_hold_after_w1c", 32'(irq), 32'h1);
        tick();
        check("irq_cleared", 32'(irq), 32'h0);

        // W1C on bit 2 coincident with its capture: the set wins.
        in_port = 4'h5;
        tick();
        repeat (L) tick();
        write_n   = 1'b0;
        writedata = 32'h4;
        tick();                       // edge L+1: set and clear together
        write_n   = 1'b1;
        tick();
        check("setwins_edgecap", readdata, 32'h4);
        check("setwins_irq_masked", 32'(irq), 32'h0);
        wr(2'd2, 32'h4);
        tick();
        check("setwins_irq", 32'(irq), 32'h1);

        // Reset mid-debounce of bit 1 with irq asserted.
        sel(2'd0);
        in_port = 4'h7;
        tick();
        repeat (6) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset_readdata", readdata, 32'h0);
        check("midreset_irq", 32'(irq), 32'h0);
        sel(2'd2);
        tick();
        check("midreset_irqmask", readdata, 32'h0);
        sel(2'd3);
        tick();
        check("midreset_edgecap", readdata, 32'h0);
        sel(2'd0);
        repeat (L - 1) tick();
        check("midreset_data_before", readdata, 32'h0);
        tick();
        check("midreset_data_after", readdata, 32'h7);
        sel(2'd3);
        tick();
        check("held_high_capture", readdata, 32'h7);
        check("held_high_irq", 32'(irq), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
